// File: rtl/structs_pkg.sv
// Shared definitions for the commit-side trap sequencer: the special-instruction
// and privilege encodings used by the ROB and csr, the trap mcause values and
// the sequencer state type.
package structs_pkg;

  // Special-instruction encoding carried on the ROB head
  localparam logic [1:0] NONE  = 2'd0;
  localparam logic [1:0] ECALL = 2'd1;
  localparam logic [1:0] MRET  = 2'd2;

  // Privilege levels reported by csr
  localparam logic [1:0] U = 2'd0;
  localparam logic [1:0] M = 2'd3;

  // Trap causes
  localparam logic [7:0] MCAUSE_ILLEGAL_INSN = 8'd2;
  localparam logic [7:0] MCAUSE_ECALL_U      = 8'd8;
  localparam logic [7:0] MCAUSE_ECALL_M      = 8'd11;

  // MRET_ST is kept in the encoding for the csr team's state decoder; the
  // sequencer goes from IDLE straight to FLUSH for a legal MRET.
  typedef enum logic [2:0] {
    IDLE,
    TRAP,
    MRET_ST,
    FLUSH,
    REDIRECT
  } trap_state_t;

  // The csr picks the ECALL cause from the current privilege.
  function automatic logic [7:0] ecall_cause(input logic [1:0] priv);
    return (priv == M) ? MCAUSE_ECALL_M : MCAUSE_ECALL_U;
  endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Bundle of the ROB head, csr and pipeline flush/redirect signals seen by
// trap_ctrl. The slave modport is the trap sequencer, master is its environment.
interface trap_ctrl_if #(
  parameter int XLEN = 32
);

  logic            head_valid;
  logic [XLEN-1:0] head_pc;
  logic            head_exc;
  logic [7:0]      head_mcause;
  logic [1:0]      head_special;
  logic            head_csr_write;
  logic [1:0]      curr_priv;
  logic [XLEN-1:0] mtvec_ReadData;
  logic [XLEN-1:0] mepc_ReadData;
  logic            flush_ack;

  logic            head_ready;
  logic            csr_valid_write;
  logic [1:0]      csr_special;
  logic            exception;
  logic [XLEN-1:0] mepc_WriteData;
  logic [7:0]      mcause;
  logic            flush;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output head_valid, head_pc, head_exc, head_mcause, head_special,
           head_csr_write, curr_priv, mtvec_ReadData, mepc_ReadData, flush_ack,
    input  head_ready, csr_valid_write, csr_special, exception, mepc_WriteData,
           mcause, flush, redirect_valid, redirect_pc
  );

  modport slave (
    input  head_valid, head_pc, head_exc, head_mcause, head_special,
           head_csr_write, curr_priv, mtvec_ReadData, mepc_ReadData, flush_ack,
    output head_ready, csr_valid_write, csr_special, exception, mepc_WriteData,
           mcause, flush, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/trap_perf_cnt.sv
// Saturating count of traps taken. Only built when TRAP_PERF_CNT_EN is defined.
`ifdef TRAP_PERF_CNT_EN
module trap_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Advance by one per trap, holding at all-ones
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Counter register, cleared by the active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`endif

// File: rtl/trap_ctrl.sv
// Commit-side trap sequencer between the ROB head and csr. Classifies the
// committing head, strobes csr, flushes the pipeline with a handshake and then
// issues a single PC redirect (mtvec base for traps, mepc for MRET).
// Optional trap counter enabled by defining TRAP_PERF_CNT_EN.
module trap_ctrl
  import structs_pkg::*;
#(
  parameter int         XLEN           = 32,
  parameter logic [7:0] MCAUSE_ILLEGAL = MCAUSE_ILLEGAL_INSN
`ifdef TRAP_PERF_CNT_EN
  ,
  parameter int         CNT_W          = 32
`endif
) (
  input  logic             clk,
  input  logic             reset,
  trap_ctrl_if.slave       bus
`ifdef TRAP_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] trap_count
`endif
);

  localparam logic [XLEN-1:0] MTVEC_BASE_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  trap_state_t     state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [7:0]      cause_q, cause_d;
  logic [XLEN-1:0] target_q, target_d;
  logic            ecall_q, ecall_d;

  logic            is_mret;
  logic            is_ecall;
  logic            illegal;
  logic            trap;

  logic            head_ready_c;
  logic            csr_valid_write_c;
  logic [1:0]      csr_special_c;

  // Classify the head: U-mode CSR writes and MRETs are illegal
  always_comb begin
    is_mret  = (bus.head_special == MRET);
    is_ecall = (bus.head_special == ECALL);
    illegal  = (bus.head_csr_write | is_mret) & (bus.curr_priv == U);
    trap     = bus.head_exc | illegal | is_ecall;
  end

  // Next-state and output decode; head is only consumed while IDLE
  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    cause_d            = cause_q;
    target_d           = target_q;
    ecall_d            = ecall_q;
    head_ready_c       = 1'b0;
    csr_valid_write_c  = 1'b0;
    csr_special_c      = NONE;
    bus.exception      = 1'b0;
    bus.mepc_WriteData = '0;
    bus.mcause         = '0;
    bus.flush          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    case (state_q)
      IDLE: begin
        if (bus.head_valid) begin
          head_ready_c = 1'b1;
          if (trap) begin
            pc_d    = bus.head_pc;
            cause_d = bus.head_exc ? bus.head_mcause :
                      illegal      ? MCAUSE_ILLEGAL  : 8'd0;
            ecall_d = ~bus.head_exc & ~illegal & is_ecall;
            state_d = TRAP;
          end else if (is_mret) begin
            csr_special_c = MRET;
            target_d      = bus.mepc_ReadData;
            state_d       = FLUSH;
          end else begin
            csr_valid_write_c = bus.head_csr_write;
          end
        end
      end

      TRAP: begin
        bus.exception      = 1'b1;
        bus.mepc_WriteData = pc_q;
        bus.mcause         = cause_q;
        csr_special_c      = ecall_q ? ECALL : NONE;
        target_d           = bus.mtvec_ReadData & MTVEC_BASE_MASK;
        state_d            = FLUSH;
      end

      FLUSH: begin
        bus.flush = 1'b1;
        if (bus.flush_ack) begin
          state_d = REDIRECT;
        end
      end

      REDIRECT: begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target_q;
        state_d            = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Head-facing strobes are combinational in IDLE, so mask them while in reset
  assign bus.head_ready      = head_ready_c & reset;
  assign bus.csr_valid_write = csr_valid_write_c & reset;
  assign bus.csr_special     = csr_special_c & {2{reset}};

  // Sequencer state and latched trap context
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      cause_q  <= '0;
      target_q <= '0;
      ecall_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cause_q  <= cause_d;
      target_q <= target_d;
      ecall_q  <= ecall_d;
    end
  end

`ifdef TRAP_PERF_CNT_EN
  trap_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_perf_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (state_q == TRAP),
    .count (trap_count)
  );
`endif

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: exception, ECALL, MRET, illegal U-mode ops,
// held flush, plain CSR writes and reset in the middle of a flush.
// Counter checks are included when TRAP_PERF_CNT_EN is defined.
module tb_trap_ctrl;
  import structs_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;
  int   exp_count   = 0;

  trap_ctrl_if #(.XLEN(32)) bus ();

`ifdef TRAP_PERF_CNT_EN
  logic [31:0] trap_count;
`endif

  // {head_ready, csr_valid_write, csr_special[1:0], exception, flush, redirect_valid}
  logic [6:0] ctl;
  assign ctl = {bus.head_ready, bus.csr_valid_write, bus.csr_special,
                bus.exception, bus.flush, bus.redirect_valid};

  always #5 clk = ~clk;

  trap_ctrl #(
    .XLEN           (32),
    .MCAUSE_ILLEGAL (8'd2)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
`ifdef TRAP_PERF_CNT_EN
    ,
    .trap_count (trap_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.head_valid     = 1'b0;
    bus.head_exc       = 1'b0;
    bus.head_mcause    = 8'd0;
    bus.head_special   = NONE;
    bus.head_csr_write = 1'b0;
    bus.flush_ack      = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.head_pc        = 32'h0;
    bus.curr_priv      = M;
    bus.mtvec_ReadData = 32'h0;
    bus.mepc_ReadData  = 32'h0;
    #2 rst_n = 1'b0;
    bus.head_valid     = 1'b1;
    bus.head_special   = MRET;
    bus.head_csr_write = 1'b1;
    #1;
    vectors++;
    if (ctl !== 7'b0000000) begin
      miscompares++; $display("[TB] FAIL rst_ctl: got %b expected %b", ctl, 7'b0000000);
    end
    vectors++;
    if ({bus.mepc_WriteData, bus.mcause, bus.redirect_pc} !== 72'h0) begin
      miscompares++; $display("[TB] FAIL rst_data: got %0h/%0h/%0h expected 0/0/0",
                              bus.mepc_WriteData, bus.mcause, bus.redirect_pc);
    end
`ifdef TRAP_PERF_CNT_EN
    vectors++;
    if (trap_count !== 32'd0) begin
      miscompares++; $display("[TB] FAIL rst_count: got %0d expected 0", trap_count);
    end
`endif
    tick();
    tick();
    vectors++;
    if (ctl !== 7'b0000000) begin
      miscompares++; $display("[TB] FAIL rst_hold_ctl: got %b expected %b", ctl, 7'b0000000);
    end
    idle_inputs();
    rst_n = 1'b1;
    #1;
    vectors++;
    if (ctl !== 7'b0000000) begin
      miscompares++; $display("[TB] FAIL rst_release_ctl: got %b expected %b", ctl, 7'b0000000);
    end
  endtask

  task automatic test_exception();
    bus.curr_priv      = M;
    bus.mtvec_ReadData = 32'h803;
    bus.head_valid     = 1'b1;
    bus.head_exc       = 1'b1;
    bus.head_mcause    = 8'd5;
    bus.head_pc        = 32'h100;
    #1;
    vectors++;
    if (ctl !== 7'b1000000) begin
      miscompares++; $display("[TB] FAIL exc_idle_ctl: got %b expected %b", ctl, 7'b1000000);
    end
    tick();
    idle_inputs();
    #1;
    vectors++;
    if (ctl !== 7'b0000100) begin
      miscompares++; $display("[TB] FAIL exc_trap_ctl: got %b expected %b", ctl, 7'b0000100);
    end
    vectors++;
    if (bus.mcause !== 8'd5) begin
      miscompares++; $display("[TB] FAIL exc_mcause: got %0d expected 5", bus.mcause);
    end
    vectors++;
    if (bus.mepc_WriteData !== 32'h100) begin
      miscompares++; $display("[TB] FAIL exc_mepc: got %0h expected 100", bus.mepc_WriteData);
    end
    exp_count++;
    tick();
    vectors++;
    if (ctl !== 7'b0000010) begin
      miscompares++; $display("[TB] FAIL exc_flush_ctl: got %b expected %b", ctl, 7'b0000010);
    end
    tick();
    vectors++;
    if (ctl !== 7'b0000010) begin
      miscompares++; $display("[TB] FAIL exc_flush_hold: got %b expected %b", ctl, 7'b0000010);
    end
    bus.flush_ack = 1'b1;
    #1;
    vectors++;
    if (ctl !== 7'b0000010) begin
      miscompares++; $display("[TB] FAIL exc_flush_ack_ctl: got %b expected %b", ctl, 7'b0000010);
    end
    tick();
    bus.flush_ack = 1'b0;
    #1;
    vectors++;
    if (ctl !== 7'b0000001) begin
      miscompares++; $display("[TB] FAIL exc_redirect_ctl: got %b expected %b", ctl, 7'b0000001);
    end
    vectors++;
    if (bus.redirect_pc !== 32'h800) begin
      miscompares++; $display("[TB] FAIL exc_redirect_pc: got %0h expected 800", bus.redirect_pc);
    end
`ifdef TRAP_PERF_CNT_EN
    vectors++;
    if (trap_count !== 32'(exp_count)) begin
      miscompares++; $display("[TB] FAIL exc_count: got %0d expected %0d", trap_count, exp_count);
    end
`endif
    tick();
    vectors++;
    if (ctl !== 7'b0000000) begin
      miscompares++; $display("[TB] FAIL exc_back_idle: got %b expected %b", ctl, 7'b0000000);
    end
  endtask

  task automatic test_ecall();
    bus.curr_priv      = U;
    bus.mtvec_ReadData = 32'h1001;
    bus.head_valid     = 1'b1;
    bus.head_special   = ECALL;
    bus.head_pc        = 32'h40;
    #1;
    vectors++;
    if (ctl !== 7'b1000000) begin
      miscompares++; $display("[TB] FAIL ecall_idle_ctl: got %b expected %b", ctl, 7'b1000000);
    end
    tick();
    vectors++;
    if (ctl !== 7'b0001100) begin
      miscompares++; $display("[TB] FAIL ecall_trap_ctl: got %b expected %b", ctl, 7'b0001100);
    end
    vectors++;
    if ({bus.mepc_WriteData, bus.mcause} !== {32'h40, 8'd0}) begin
      miscompares++; $display("[TB] FAIL ecall_mepc_cause: got %0h/%0d expected 40/0",
                              bus.mepc_WriteData, bus.mcause);
    end
    exp_count++;
    bus.flush_ack = 1'b1;
    tick();
    vectors++;
    if (ctl !== 7'b0000010) begin
      miscompares++; $display("[TB] FAIL ecall_flush_ctl: got %b expected %b", ctl, 7'b0000010);
    end
    tick();
    idle_inputs();
    #1;
    vectors++;
    if (ctl !== 7'b0000001) begin
      miscompares++; $display("[TB] FAIL ecall_redirect_ctl: got %b expected %b", ctl, 7'b0000001);
    end
    vectors++;
    if (bus.redirect_pc !== 32'h1000) begin
      miscompares++; $display("[TB] FAIL ecall_redirect_pc: got %0h expected 1000", bus.redirect_pc);
    end
    tick();
    vectors++;
    if (ctl !== 7'b0000000) begin
      miscompares++; $display("[TB] FAIL ecall_back_idle: got %b expected %b", ctl, 7'b0000000);
    end
  endtask

  task automatic test_mret();
    bus.curr_priv     = M;
    bus.mepc_ReadData = 32'h2000;
    bus.head_valid    = 1'b1;
    bus.head_special  = MRET;
    bus.head_pc       = 32'h300;
    #1;
    vectors++;
    if (ctl !== 7'b1010000) begin
      miscompares++; $display("[TB] FAIL mret_idle_ctl: got %b expected %b", ctl, 7'b1010000);
    end
    tick();
    idle_inputs();
    bus.mepc_ReadData = 32'h9999;
    #1;
    vectors++;
    if (ctl !== 7'b0000010) begin
      miscompares++; $display("[TB] FAIL mret_flush_ctl: got %b expected %b", ctl, 7'b0000010);
    end
    bus.flush_ack = 1'b1;
    tick();
    bus.flush_ack = 1'b0;
    #1;
    vectors++;
    if (ctl !== 7'b0000001) begin
      miscompares++; $display("[TB] FAIL mret_redirect_ctl: got %b expected %b", ctl, 7'b0000001);
    end
    vectors++;
    if (bus.redirect_pc !== 32'h2000) begin
      miscompares++; $display("[TB] FAIL mret_redirect_pc: got %0h expected 2000", bus.redirect_pc);
    end
`ifdef TRAP_PERF_CNT_EN
    vectors++;
    if (trap_count !== 32'(exp_count)) begin
      miscompares++; $display("[TB] FAIL mret_count: got %0d expected %0d", trap_count, exp_count);
    end
`endif
    tick();
    vectors++;
    if (ctl !== 7'b0000000) begin
      miscompares++; $display("[TB] FAIL mret_back_idle: got %b expected %b", ctl, 7'b0000000);
    end
  endtask

  task automatic test_illegal();
    bus.curr_priv      = U;
    bus.mtvec_ReadData = 32'h600;
    bus.head_valid     = 1'b1;
    bus.head_csr_write = 1'b1;
    bus.head_pc        = 32'h500;
    #1;
    vectors++;
    if (ctl !== 7'b1000000) begin
      miscompares++; $display("[TB] FAIL ill_csr_idle_ctl: got %b expected %b", ctl, 7'b1000000);
    end
    tick();
    idle_inputs();
    #1;
    vectors++;
    if (ctl !== 7'b0000100) begin
      miscompares++; $display("[TB] FAIL ill_csr_trap_ctl: got %b expected %b", ctl, 7'b0000100);
    end
    vectors++;
    if ({bus.mepc_WriteData, bus.mcause} !== {32'h500, 8'd2}) begin
      miscompares++; $display("[TB] FAIL ill_csr_mepc_cause: got %0h/%0d expected 500/2",
                              bus.mepc_WriteData, bus.mcause);
    end
    exp_count++;
    bus.flush_ack = 1'b1;
    tick();
    tick();
    bus.flush_ack = 1'b0;
    #1;
    vectors++;
    if ({ctl, bus.redirect_pc} !== {7'b0000001, 32'h600}) begin
      miscompares++; $display("[TB] FAIL ill_csr_redirect: got %b/%0h expected 0000001/600",
                              ctl, bus.redirect_pc);
    end
    bus.head_valid    = 1'b1;
    bus.head_special  = MRET;
    bus.head_pc       = 32'h504;
    bus.mepc_ReadData = 32'h7777;
    tick();
    vectors++;
    if (ctl !== 7'b1000000) begin
      miscompares++; $display("[TB] FAIL ill_mret_idle_ctl: got %b expected %b", ctl, 7'b1000000);
    end
    tick();
    idle_inputs();
    #1;
    vectors++;
    if (ctl !== 7'b0000100) begin
      miscompares++; $display("[TB] FAIL ill_mret_trap_ctl: got %b expected %b", ctl, 7'b0000100);
    end
    vectors++;
    if ({bus.mepc_WriteData, bus.mcause} !== {32'h504, 8'd2}) begin
      miscompares++; $display("[TB] FAIL ill_mret_mepc_cause: got %0h/%0d expected 504/2",
                              bus.mepc_WriteData, bus.mcause);
    end
    exp_count++;
    bus.flush_ack = 1'b1;
    tick();
    tick();
    bus.flush_ack = 1'b0;
    #1;
    vectors++;
    if ({ctl, bus.redirect_pc} !== {7'b0000001, 32'h600}) begin
      miscompares++; $display("[TB] FAIL ill_mret_redirect: got %b/%0h expected 0000001/600",
                              ctl, bus.redirect_pc);
    end
    tick();
    vectors++;
    if (ctl !== 7'b0000000) begin
      miscompares++; $display("[TB] FAIL ill_back_idle: got %b expected %b", ctl, 7'b0000000);
    end
  endtask

  task automatic test_back_to_back();
    bus.curr_priv      = M;
    bus.head_valid     = 1'b1;
    bus.head_csr_write = 1'b1;
    #1;
    vectors++;
    if (ctl !== 7'b1100000) begin
      miscompares++; $display("[TB] FAIL b2b_csr_first: got %b expected %b", ctl, 7'b1100000);
    end
    tick();
    vectors++;
    if (ctl !== 7'b1100000) begin
      miscompares++; $display("[TB] FAIL b2b_csr_second: got %b expected %b", ctl, 7'b1100000);
    end
    bus.head_csr_write = 1'b0;
    #1;
    vectors++;
    if (ctl !== 7'b1000000) begin
      miscompares++; $display("[TB] FAIL b2b_plain_commit: got %b expected %b", ctl, 7'b1000000);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_flush_hold();
    bus.curr_priv      = M;
    bus.mtvec_ReadData = 32'h204;
    bus.head_valid     = 1'b1;
    bus.head_exc       = 1'b1;
    bus.head_mcause    = 8'd7;
    bus.head_pc        = 32'h80;
    #1;
    vectors++;
    if (ctl !== 7'b1000000) begin
      miscompares++; $display("[TB] FAIL hold_idle_ctl: got %b expected %b", ctl, 7'b1000000);
    end
    tick();
    vectors++;
    if ({ctl, bus.mcause} !== {7'b0000100, 8'd7}) begin
      miscompares++; $display("[TB] FAIL hold_trap: got %b/%0d expected 0000100/7", ctl, bus.mcause);
    end
    exp_count++;
    bus.head_exc       = 1'b0;
    bus.head_csr_write = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (ctl !== 7'b0000010) begin
        miscompares++; $display("[TB] FAIL hold_flush_ctl[%0d]: got %b expected %b", i, ctl, 7'b0000010);
      end
    end
    bus.flush_ack = 1'b1;
    #1;
    vectors++;
    if (ctl !== 7'b0000010) begin
      miscompares++; $display("[TB] FAIL hold_ack_ctl: got %b expected %b", ctl, 7'b0000010);
    end
    tick();
    idle_inputs();
    #1;
    vectors++;
    if ({ctl, bus.redirect_pc} !== {7'b0000001, 32'h204}) begin
      miscompares++; $display("[TB] FAIL hold_redirect: got %b/%0h expected 0000001/204",
                              ctl, bus.redirect_pc);
    end
    tick();
    vectors++;
    if (ctl !== 7'b0000000) begin
      miscompares++; $display("[TB] FAIL hold_back_idle: got %b expected %b", ctl, 7'b0000000);
    end
  endtask

  task automatic test_reset_mid();
    bus.curr_priv      = M;
    bus.mtvec_ReadData = 32'h20;
    bus.head_valid     = 1'b1;
    bus.head_exc       = 1'b1;
    bus.head_mcause    = 8'd3;
    bus.head_pc        = 32'h10;
    tick();
    idle_inputs();
    #1;
    vectors++;
    if (ctl !== 7'b0000100) begin
      miscompares++; $display("[TB] FAIL rmid_trap_ctl: got %b expected %b", ctl, 7'b0000100);
    end
    exp_count++;
    tick();
    vectors++;
    if (ctl !== 7'b0000010) begin
      miscompares++; $display("[TB] FAIL rmid_flush_ctl: got %b expected %b", ctl, 7'b0000010);
    end
`ifdef TRAP_PERF_CNT_EN
    vectors++;
    if (trap_count !== 32'(exp_count)) begin
      miscompares++; $display("[TB] FAIL rmid_count_pre: got %0d expected %0d", trap_count, exp_count);
    end
`endif
    rst_n = 1'b0;
    exp_count = 0;
    #1;
    vectors++;
    if ({ctl, bus.mepc_WriteData, bus.mcause, bus.redirect_pc} !== 79'h0) begin
      miscompares++; $display("[TB] FAIL rmid_reset_outputs: got %b/%0h/%0h/%0h expected 0/0/0/0",
                              ctl, bus.mepc_WriteData, bus.mcause, bus.redirect_pc);
    end
`ifdef TRAP_PERF_CNT_EN
    vectors++;
    if (trap_count !== 32'd0) begin
      miscompares++; $display("[TB] FAIL rmid_count_reset: got %0d expected 0", trap_count);
    end
`endif
    bus.flush_ack  = 1'b1;
    bus.head_valid = 1'b1;
    bus.head_exc   = 1'b1;
    tick();
    vectors++;
    if (ctl !== 7'b0000000) begin
      miscompares++; $display("[TB] FAIL rmid_in_reset_ctl: got %b expected %b", ctl, 7'b0000000);
    end
    idle_inputs();
    rst_n = 1'b1;
    tick();
    vectors++;
    if (ctl !== 7'b0000000) begin
      miscompares++; $display("[TB] FAIL rmid_after_release: got %b expected %b", ctl, 7'b0000000);
    end
    bus.head_valid  = 1'b1;
    bus.head_exc    = 1'b1;
    bus.head_mcause = 8'd4;
    bus.head_pc     = 32'h30;
    #1;
    vectors++;
    if (ctl !== 7'b1000000) begin
      miscompares++; $display("[TB] FAIL rmid_new_idle_ctl: got %b expected %b", ctl, 7'b1000000);
    end
    tick();
    idle_inputs();
    #1;
    vectors++;
    if ({ctl, bus.mcause, bus.mepc_WriteData} !== {7'b0000100, 8'd4, 32'h30}) begin
      miscompares++; $display("[TB] FAIL rmid_new_trap: got %b/%0d/%0h expected 0000100/4/30",
                              ctl, bus.mcause, bus.mepc_WriteData);
    end
    exp_count++;
    tick();
`ifdef TRAP_PERF_CNT_EN
    vectors++;
    if (trap_count !== 32'(exp_count)) begin
      miscompares++; $display("[TB] FAIL rmid_count_post: got %0d expected %0d", trap_count, exp_count);
    end
`endif
    bus.flush_ack = 1'b1;
    tick();
    bus.flush_ack = 1'b0;
    #1;
    vectors++;
    if ({ctl, bus.redirect_pc} !== {7'b0000001, 32'h20}) begin
      miscompares++; $display("[TB] FAIL rmid_new_redirect: got %b/%0h expected 0000001/20",
                              ctl, bus.redirect_pc);
    end
    tick();
    vectors++;
    if (ctl !== 7'b0000000) begin
      miscompares++; $display("[TB] FAIL rmid_back_idle: got %b expected %b", ctl, 7'b0000000);
    end
  endtask

  initial begin
    test_reset();
    test_exception();
    test_ecall();
    test_mret();
    test_illegal();
    test_back_to_back();
    test_flush_hold();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
